sha256_stream_arbiter: RTL and testbench

- Shares one single-block SHA-256 core between NUM_REQ AXI4-Stream requesters.
- Arbitrates round-robin at message granularity and forwards the winner's byte stream to the core.
- Tags the returned 8-word digest with the requester ID and streams it to a common result port.
- Sits between the message sources and the hash core in the same clock domain.

---
 rtl/sha256_stream_arbiter_if.sv | 53 +++++
 rtl/sha256_stream_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_sha256_stream_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_stream_arbiter_if.sv
// sha256_stream_arbiter_if
// Bundles the requester streams, the byte stream to the hash core, the digest
// stream returned by the core and the tagged result stream.
// The master modport is the arbiter's view; slave is the surrounding system.
interface sha256_stream_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  // Requester side
  logic [NUM_REQ-1:0]    s_axis_tvalid;
  logic [32*NUM_REQ-1:0] s_axis_tdata;
  logic [NUM_REQ-1:0]    s_axis_tlast;
  logic [NUM_REQ-1:0]    s_axis_tready;
  // Byte stream towards the core
  logic                  core_tvalid;
  logic [31:0]           core_tdata;
  logic [3:0]            core_tkeep;
  logic                  core_tlast;
  logic                  core_tready;
  // Digest words coming back from the core
  logic                  core_res_tvalid;
  logic [31:0]           core_res_tdata;
  logic                  core_res_tready;
  // Tagged digest output
  logic                  m_axis_tvalid;
  logic [31:0]           m_axis_tdata;
  logic                  m_axis_tlast;
  logic [ID_W-1:0]       m_axis_tdest;
  logic                  m_axis_tuser;
  logic                  m_axis_tready;

  modport master (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tlast,
    output s_axis_tready,
    output core_tvalid, core_tdata, core_tkeep, core_tlast,
    input  core_tready,
    input  core_res_tvalid, core_res_tdata,
    output core_res_tready,
    output m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tdest, m_axis_tuser,
    input  m_axis_tready
  );

  modport slave (
    output s_axis_tvalid, s_axis_tdata, s_axis_tlast,
    input  s_axis_tready,
    input  core_tvalid, core_tdata, core_tkeep, core_tlast,
    output core_tready,
    output core_res_tvalid, core_res_tdata,
    input  core_res_tready,
    input  m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tdest, m_axis_tuser,
    output m_axis_tready
  );
endinterface

// File: rtl/sha256_stream_arbiter.sv
// sha256_stream_arbiter
// Shares one single-block SHA-256 core between NUM_REQ byte-stream requesters.
// Whole messages are granted round-robin, forwarded to the core, and the
// returned 8-word digest is tagged with the owner's ID on m_axis_tdest.
// Optional length guard: define SHA256_ARB_LENGTH_GUARD_EN to cut messages at
// MAX_BYTES, drain the remainder and flag the digest on m_axis_tuser.
module sha256_stream_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int MAX_BYTES = 55
) (
  input  logic                    m_axis_aclk,
  input  logic                    m_axis_aresetn,
  sha256_stream_arbiter_if.master bus,
  output logic                    busy,
  output logic [15:0]             msg_count
);

`ifdef SHA256_ARB_LENGTH_GUARD_EN
  typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_DIGEST, ST_DRAIN} state_t;
  // byte_cnt value of the last beat the core may receive
  localparam logic [5:0] BYTE_LIMIT = 6'(MAX_BYTES - 1);
`else
  typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_DIGEST} state_t;
  localparam int unused_max_bytes = MAX_BYTES;
`endif

  state_t          state_reg, state_next;
  logic [ID_W-1:0] grant_reg, grant_next;
  logic [ID_W-1:0] last_grant_reg, last_grant_next;
  logic [5:0]      byte_cnt_reg, byte_cnt_next;
  logic [2:0]      word_cnt_reg, word_cnt_next;
  logic [15:0]     msg_count_reg, msg_count_next;
`ifdef SHA256_ARB_LENGTH_GUARD_EN
  logic            err_flag_reg, err_flag_next;
`endif

  logic [7:0]            req_byte [NUM_REQ];
  logic [24*NUM_REQ-1:0] unused_tdata_hi;
  logic                  arb_found;
  logic [ID_W-1:0]       arb_winner;
  logic [NUM_REQ-1:0]    s_tready;
  logic                  core_tvalid, core_tlast, res_tready;
  logic [7:0]            core_byte;
  logic                  out_tvalid, out_tlast, out_tuser;
  logic [31:0]           out_tdata;
  logic [ID_W-1:0]       out_tdest;

  // Only the low byte of each requester lane carries payload.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign req_byte[gi]                 = bus.s_axis_tdata[32*gi +: 8];
    assign unused_tdata_hi[24*gi +: 24] = bus.s_axis_tdata[32*gi+8 +: 24];
  end

  // Round-robin scan beginning just after the previous winner.
  always_comb begin
    logic [ID_W-1:0] cand;
    cand       = '0;
    arb_found  = 1'b0;
    arb_winner = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((int'(last_grant_reg) + i) % NUM_REQ);
      if (!arb_found && bus.s_axis_tvalid[cand]) begin
        arb_found  = 1'b1;
        arb_winner = cand;
      end
    end
  end

  // Next-state logic plus per-state routing of the request and digest streams.
  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    byte_cnt_next   = byte_cnt_reg;
    word_cnt_next   = word_cnt_reg;
    msg_count_next  = msg_count_reg;
`ifdef SHA256_ARB_LENGTH_GUARD_EN
    err_flag_next   = err_flag_reg;
`endif
    s_tready        = '0;
    core_tvalid     = 1'b0;
    core_tlast      = 1'b0;
    core_byte       = 8'd0;
    res_tready      = 1'b0;
    out_tvalid      = 1'b0;
    out_tdata       = 32'd0;
    out_tlast       = 1'b0;
    out_tdest       = '0;
    out_tuser       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (arb_found) begin
          grant_next = arb_winner;
          state_next = ST_FWD;
        end
      end
      ST_FWD: begin
        core_tvalid         = bus.s_axis_tvalid[grant_reg];
        core_tlast          = bus.s_axis_tlast[grant_reg];
        core_byte           = req_byte[grant_reg];
        s_tready[grant_reg] = bus.core_tready;
`ifdef SHA256_ARB_LENGTH_GUARD_EN
        // The beat at the length limit always closes the core's message.
        if (byte_cnt_reg == BYTE_LIMIT) core_tlast = 1'b1;
`endif
        if (core_tvalid && bus.core_tready) begin
          if (bus.s_axis_tlast[grant_reg]) begin
            byte_cnt_next = '0;
            state_next    = ST_DIGEST;
          end
`ifdef SHA256_ARB_LENGTH_GUARD_EN
          else if (byte_cnt_reg == BYTE_LIMIT) begin
            byte_cnt_next = '0;
            err_flag_next = 1'b1;
            state_next    = ST_DRAIN;
          end
`endif
          else begin
            byte_cnt_next = byte_cnt_reg + 6'd1;
          end
        end
      end
`ifdef SHA256_ARB_LENGTH_GUARD_EN
      ST_DRAIN: begin
        // Swallow the over-long tail; the core already saw its last byte.
        s_tready[grant_reg] = 1'b1;
        if (bus.s_axis_tvalid[grant_reg] && bus.s_axis_tlast[grant_reg])
          state_next = ST_DIGEST;
      end
`endif
      ST_DIGEST: begin
        out_tvalid = bus.core_res_tvalid;
        out_tdata  = bus.core_res_tdata;
        out_tdest  = grant_reg;
        out_tlast  = (word_cnt_reg == 3'd7);
        res_tready = bus.m_axis_tready;
`ifdef SHA256_ARB_LENGTH_GUARD_EN
        out_tuser  = err_flag_reg;
`endif
        if (bus.core_res_tvalid && bus.m_axis_tready) begin
          word_cnt_next = word_cnt_reg + 3'd1;
          if (word_cnt_reg == 3'd7) begin
            state_next      = ST_IDLE;
            last_grant_next = grant_reg;
            msg_count_next  = msg_count_reg + 16'd1;
`ifdef SHA256_ARB_LENGTH_GUARD_EN
            err_flag_next   = 1'b0;
`endif
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= '0;
      last_grant_reg <= ID_W'(NUM_REQ - 1);
      byte_cnt_reg   <= '0;
      word_cnt_reg   <= '0;
      msg_count_reg  <= '0;
`ifdef SHA256_ARB_LENGTH_GUARD_EN
      err_flag_reg   <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      byte_cnt_reg   <= byte_cnt_next;
      word_cnt_reg   <= word_cnt_next;
      msg_count_reg  <= msg_count_next;
`ifdef SHA256_ARB_LENGTH_GUARD_EN
      err_flag_reg   <= err_flag_next;
`endif
    end
  end

  assign bus.s_axis_tready   = s_tready;
  assign bus.core_tvalid     = core_tvalid;
  assign bus.core_tdata      = {24'd0, core_byte};
  assign bus.core_tkeep      = 4'b0001;
  assign bus.core_tlast      = core_tlast;
  assign bus.core_res_tready = res_tready;
  assign bus.m_axis_tvalid   = out_tvalid;
  assign bus.m_axis_tdata    = out_tdata;
  assign bus.m_axis_tlast    = out_tlast;
  assign bus.m_axis_tdest    = out_tdest;
  assign bus.m_axis_tuser    = out_tuser;
  assign busy                = (state_reg != ST_IDLE);
  assign msg_count           = msg_count_reg;

endmodule

// File: tb/tb_sha256_stream_arbiter.sv
// tb_sha256_stream_arbiter
// Directed bench: requester sources, a stub hash core and a result sink run in
// one environment process; expected digest words are queued per message and
// compared as the arbiter delivers them.
module tb_sha256_stream_arbiter;
  localparam int NR = 4;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  dest;
    logic        last;
    logic        user;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic [15:0] msg_count;
  int errors = 0;
  int checks = 0;

  exp_t        sb[$];
  logic [8:0]  src_q [NR][$];
  logic [7:0]  coll[$];
  logic [31:0] res_q[$];
  int          core_lens[$];
  int          gaps[$];
  int          cyc = 0;
  int          last_word_cyc = 0;
  int          first_cv_cyc = 0;
  bit          core_rand = 1'b0;
  bit          sink_rand = 1'b0;
  bit          sink_script[$];
  logic [31:0] abc_dig [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                               32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

  always #5 clk = ~clk;

  sha256_stream_arbiter_if #(.NUM_REQ(NR), .ID_W(2)) bus ();

  sha256_stream_arbiter #(.NUM_REQ(NR), .ID_W(2), .MAX_BYTES(55)) dut (
    .m_axis_aclk    (clk),
    .m_axis_aresetn (rst_n),
    .bus            (bus),
    .busy           (busy),
    .msg_count      (msg_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stub core digest: the real SHA-256 value for "abc", an order-sensitive hash otherwise.
  function automatic logic [31:0] dig_word(input logic [7:0] b[$], input int i);
    logic [31:0] h;
    h = 32'h811c9dc5;
    if (b.size() == 3 && b[0] == 8'h61 && b[1] == 8'h62 && b[2] == 8'h63) return abc_dig[i];
    foreach (b[k]) h = (h ^ {24'd0, b[k]}) * 32'h01000193;
    return h ^ (32'(i) * 32'h9e3779b9) ^ (32'(b.size()) << 24);
  endfunction

  task automatic make_msg(input int len, input int seed, output logic [7:0] m[$]);
    m.delete();
    for (int k = 0; k < len; k++) m.push_back(8'(seed * 37 + k * 11 + 5));
  endtask

  task automatic push_msg(input int r, input logic [7:0] m[$]);
    foreach (m[k]) src_q[r].push_back({(k == m.size() - 1), m[k]});
  endtask

  task automatic expect_msg(input int r, input logic [7:0] m[$], input logic user);
    for (int i = 0; i < 8; i++)
      sb.push_back('{data: dig_word(m, i), dest: 2'(r), last: (i == 7), user: user});
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, (n < budget), 1);
  endtask

  // Asserts reset in the middle of a cycle and checks outputs before the next edge.
  task automatic apply_reset(input string tag);
    #1;
    rst_n = 1'b0;
    for (int r = 0; r < NR; r++) src_q[r].delete();
    coll.delete();
    res_q.delete();
    #1;
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_msg_count"}, msg_count, 0);
    chk({tag, "_outputs"}, {bus.s_axis_tready, bus.core_tvalid, bus.core_tlast, bus.core_res_tready,
                            bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tuser, bus.m_axis_tdest}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Environment: requester sources, stub core and result sink.
  initial begin : env
    exp_t             e;
    logic [NR-1:0]    v, l;
    logic [32*NR-1:0] d;
    bus.s_axis_tvalid   = '0;
    bus.s_axis_tdata    = '0;
    bus.s_axis_tlast    = '0;
    bus.core_tready     = 1'b1;
    bus.core_res_tvalid = 1'b0;
    bus.core_res_tdata  = 32'd0;
    bus.m_axis_tready   = 1'b1;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst_n) begin
        if (!busy)
          chk("idle_outputs", {bus.s_axis_tready, bus.core_tvalid, bus.core_res_tready, bus.m_axis_tvalid}, 0);
        for (int r = 0; r < NR; r++)
          if (bus.s_axis_tvalid[r] && bus.s_axis_tready[r]) void'(src_q[r].pop_front());
        if (bus.core_tvalid && first_cv_cyc < 0) begin
          gaps.push_back(cyc - last_word_cyc);
          first_cv_cyc = cyc;
        end
        if (bus.core_tvalid && bus.core_tready) begin
          chk("core_tkeep", bus.core_tkeep, 4'b0001);
          chk("core_tdata_hi", bus.core_tdata[31:8], 0);
          coll.push_back(bus.core_tdata[7:0]);
          if (bus.core_tlast) begin
            for (int i = 0; i < 8; i++) res_q.push_back(dig_word(coll, i));
            core_lens.push_back(coll.size());
            coll.delete();
          end
        end
        if (bus.core_res_tvalid && bus.core_res_tready) void'(res_q.pop_front());
        if (bus.m_axis_tvalid) chk("res_tready_mirror", bus.core_res_tready, bus.m_axis_tready);
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
          if (sb.size() == 0) begin
            chk("unexpected_word", bus.m_axis_tdata, 64'hdead_0000_0000);
          end else begin
            e = sb.pop_front();
            $display("word dest=%0d data=%08h last=%0b user=%0b", bus.m_axis_tdest, bus.m_axis_tdata,
                     bus.m_axis_tlast, bus.m_axis_tuser);
            chk("m_tdata", bus.m_axis_tdata, e.data);
            chk("m_tdest", bus.m_axis_tdest, e.dest);
            chk("m_tlast", bus.m_axis_tlast, e.last);
            chk("m_tuser", bus.m_axis_tuser, e.user);
            if (bus.m_axis_tlast) begin
              last_word_cyc = cyc;
              first_cv_cyc  = -1;
            end
          end
        end
      end
      #1;
      v = '0;
      l = '0;
      d = '0;
      for (int r = 0; r < NR; r++) begin
        if (src_q[r].size() != 0) begin
          v[r]          = 1'b1;
          l[r]          = src_q[r][0][8];
          d[32*r +: 32] = {8'hA5, 8'(r), 8'h5A, src_q[r][0][7:0]};
        end
      end
      bus.s_axis_tvalid   = v;
      bus.s_axis_tlast    = l;
      bus.s_axis_tdata    = d;
      bus.core_tready     = core_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.core_res_tvalid = (res_q.size() != 0);
      bus.core_res_tdata  = (res_q.size() != 0) ? res_q[0] : 32'd0;
      if (sink_script.size() != 0) bus.m_axis_tready = sink_script.pop_front();
      else bus.m_axis_tready = sink_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Directed sequence.
  initial begin : main
    logic [7:0] m[$];
    logic [7:0] m2[$];
    logic [7:0] m3[$];
    int n;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_msg_count", msg_count, 0);
    chk("rst_outputs", {bus.s_axis_tready, bus.core_tvalid, bus.core_tlast, bus.core_res_tready,
                        bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tuser, bus.m_axis_tdest}, 0);
    rst_n = 1'b1;

    // 1: "abc" on requester 1
    m = '{8'h61, 8'h62, 8'h63};
    push_msg(1, m);
    expect_msg(1, m, 1'b0);
    wait_done("t1_done", 400);
    chk("t1_core_len", (core_lens.size() > 0) ? core_lens[0] : -1, 3);
    chk("t1_msg_count", msg_count, 1);

    // 2: simultaneous requests 0, 2, 3 after reset, random core backpressure
    @(negedge clk);
    apply_reset("t2_rst");
    core_rand = 1'b1;
    make_msg(5, 1, m);  push_msg(0, m);  expect_msg(0, m, 1'b0);
    make_msg(7, 2, m2); push_msg(2, m2); expect_msg(2, m2, 1'b0);
    make_msg(3, 3, m3); push_msg(3, m3); expect_msg(3, m3, 1'b0);
    wait_done("t2_done", 1500);
    chk("t2_msg_count", msg_count, 3);
    core_rand = 1'b0;

    // 3: back-to-back single-byte messages on requester 0
    gaps.delete();
    first_cv_cyc = 0;
    m = '{8'h11};
    m2 = '{8'h22};
    push_msg(0, m);  expect_msg(0, m, 1'b0);
    push_msg(0, m2); expect_msg(0, m2, 1'b0);
    wait_done("t3_done", 600);
    chk("t3_idle_gap", (gaps.size() > 0) ? gaps[0] : -1, 2);
    chk("t3_msg_count", msg_count, 5);

    // 4: sink backpressure during the digest
    make_msg(9, 4, m);
    push_msg(3, m);
    expect_msg(3, m, 1'b0);
    n = 0;
    while (!bus.m_axis_tvalid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t4_digest_seen", bus.m_axis_tvalid, 1);
    sink_script = '{1'b1, 1'b0, 1'b0, 1'b1};
    wait_done("t4_done", 600);
    sink_rand = 1'b1;
    make_msg(6, 5, m);
    push_msg(3, m);
    expect_msg(3, m, 1'b0);
    wait_done("t4b_done", 800);
    sink_rand = 1'b0;
    chk("t4_msg_count", msg_count, 7);

    // 5: reset in the middle of a forwarded message
    make_msg(20, 6, m);
    push_msg(1, m);
    n = 0;
    while (coll.size() < 10 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reached_10", (coll.size() >= 10), 1);
    chk("t5_busy_before", busy, 1);
    apply_reset("t5_rst");
    make_msg(4, 7, m);  push_msg(2, m2);
    make_msg(4, 8, m3);
    src_q[2].delete();
    push_msg(2, m);  push_msg(0, m3);
    expect_msg(0, m3, 1'b0);
    expect_msg(2, m, 1'b0);
    wait_done("t5_done", 800);
    chk("t5_msg_count", msg_count, 2);

`ifdef SHA256_ARB_LENGTH_GUARD_EN
    // 6: over-long message is cut at 55 bytes and flagged
    make_msg(60, 9, m);
    push_msg(2, m);
    m2 = m[0:54];
    expect_msg(2, m2, 1'b1);
    wait_done("t6_done", 1500);
    chk("t6_core_len", core_lens[core_lens.size() - 1], 55);
    chk("t6_drained", src_q[2].size(), 0);
    make_msg(4, 10, m);
    push_msg(2, m);
    expect_msg(2, m, 1'b0);
    wait_done("t6b_done", 600);
    chk("t6_msg_count", msg_count, 4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
